// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB register slave.
// FSM state, address-alignment helpers, wait-state limit.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } apb_state_t;

  localparam int WAIT_MAX = 15;

  // Byte-offset bits within one data word
  function automatic int align_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Word-index bits for the register array
  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/apb_regmem.sv
// Register array: byte-enable synchronous write,
// combinational read, cleared by async reset.
module apb_regmem
  import apb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     pclk,
  input  logic                     prst,
  input  logic                     we,
  input  logic [idx_w(DEPTH)-1:0]  addr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      wstrb,
  output logic [DATA_W-1:0]        rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Clear on reset; otherwise write strobed bytes
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < NB; b++)
        if (wstrb[b])
          mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/apb_reg_slave.sv
// APB slave with a small register file and
// programmable wait states.
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                pclk,
  input  logic                prst,
  input  logic                psel,
  input  logic                pen,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr
);

  localparam int NB    = DATA_W / 8;
  localparam int ALIGN = align_w(DATA_W);
  localparam int IW    = idx_w(DEPTH);

  localparam logic [ADDR_W:0] LIMIT =
    (ADDR_W+1)'(DEPTH * NB);
  localparam logic [ADDR_W-1:0] AMASK =
    ADDR_W'(NB - 1);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  apb_state_t        state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [DATA_W-1:0] prdata_n;
  logic              pready_n;
  logic              pslverr_n;

  logic              err;
  logic              mem_we;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] mem_rdata;

  // Out of range or misaligned byte address
  assign err = ({1'b0, paddr} >= LIMIT) ||
               (|(paddr & AMASK));

  assign idx = paddr[ALIGN +: IW];

  apb_regmem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .pclk  (pclk),
    .prst  (prst),
    .we    (mem_we),
    .addr  (idx),
    .wdata (pwdata),
    .wstrb (pstrb),
    .rdata (mem_rdata)
  );

  // State, counter and response registers
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state   <= IDLE;
      cnt     <= '0;
      prdata  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      prdata  <= prdata_n;
      pready  <= pready_n;
      pslverr <= pslverr_n;
    end
  end

  // Next state, wait countdown and completion
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    prdata_n  = prdata;
    pready_n  = 1'b0;
    pslverr_n = 1'b0;
    mem_we    = 1'b0;
    unique case (state)
      IDLE: begin
        if (psel && !pen) begin
          state_n = WAIT;
          cnt_n   = WS;
        end
      end
      WAIT: begin
        if (!psel) begin
          state_n = IDLE;
        end else if (pen) begin
          if (cnt == 4'd0) begin
            state_n   = DONE;
            pready_n  = 1'b1;
            pslverr_n = err;
            if (pwrite)
              mem_we = !err;
            else
              prdata_n = err ? '0 : mem_rdata;
          end else begin
            cnt_n = cnt - 4'd1;
          end
        end
      end
      DONE: begin
        if (psel && !pen) begin
          state_n = WAIT;
          cnt_n   = WS;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave with zero
// and three wait states.
module tb_apb_reg_slave;

  logic        pclk = 1'b0;
  logic        prst;
  logic        psel0, psel3;
  logic        pen, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3;
  logic        pslverr0, pslverr3;

  int total = 0;
  int fails = 0;

  always #5 pclk = ~pclk;

  apb_reg_slave #(.WAIT_STATES(0)) dut0 (
    .pclk(pclk), .prst(prst), .psel(psel0),
    .pen(pen), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata0), .pready(pready0),
    .pslverr(pslverr0)
  );

  apb_reg_slave #(.WAIT_STATES(3)) dut3 (
    .pclk(pclk), .prst(prst), .psel(psel3),
    .pen(pen), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata3), .pready(pready3),
    .pslverr(pslverr3)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Starts on a negedge; ends on a negedge
  task automatic xfer(input bit d3, input bit wr,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0] s,
                      input bit keep,
                      output logic [31:0] rd,
                      output logic er,
                      output int cyc);
    if (d3) psel3 = 1'b1;
    else psel0 = 1'b1;
    pen = 1'b0; pwrite = wr; paddr = a;
    pwdata = d; pstrb = s;
    @(negedge pclk);
    pen = 1'b1;
    cyc = -1;
    for (int i = 2; i <= 40; i++) begin
      @(negedge pclk);
      if (d3 ? pready3 : pready0) begin
        cyc = i;
        break;
      end
    end
    rd = d3 ? prdata3 : prdata0;
    er = d3 ? pslverr3 : pslverr0;
    pen = 1'b0;
    if (!keep) begin
      psel0 = 1'b0; psel3 = 1'b0;
      @(negedge pclk);
      chk("pready_low_after",
          32'(d3 ? pready3 : pready0), 32'd0);
      chk("pslverr_low_after",
          32'(d3 ? pslverr3 : pslverr0), 32'd0);
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          cyc;

  initial begin
    prst = 1'b1; psel0 = 1'b0; psel3 = 1'b0;
    pen = 1'b0; pwrite = 1'b0; paddr = '0;
    pwdata = '0; pstrb = '0;
    #2 prst = 1'b0;
    #1;
    chk("rst_prdata", prdata0, 32'd0);
    chk("rst_pready", 32'(pready0), 32'd0);
    chk("rst_pslverr", 32'(pslverr0), 32'd0);
    chk("rst_pready3", 32'(pready3), 32'd0);
    @(negedge pclk);
    @(negedge pclk);
    prst = 1'b1;

    // Full write then read, no wait states
    xfer(0, 1, 32'h8, 32'hDEADBEEF, 4'hF, 0,
         rd, er, cyc);
    chk("wr8_cyc", 32'(cyc), 32'd2);
    chk("wr8_err", 32'(er), 32'd0);
    xfer(0, 0, 32'h8, 32'h0, 4'h0, 0, rd, er, cyc);
    chk("rd8_cyc", 32'(cyc), 32'd2);
    chk("rd8_data", rd, 32'hDEADBEEF);
    chk("rd8_err", 32'(er), 32'd0);

    // Partial strobes
    xfer(0, 1, 32'h8, 32'h11223344, 4'h3, 0,
         rd, er, cyc);
    xfer(0, 0, 32'h8, 32'h0, 4'h0, 0, rd, er, cyc);
    chk("strb_data", rd, 32'hDEAD3344);

    // Out-of-range write, misaligned read
    xfer(0, 1, 32'h40, 32'hFFFFFFFF, 4'hF, 0,
         rd, er, cyc);
    chk("oor_cyc", 32'(cyc), 32'd2);
    chk("oor_err", 32'(er), 32'd1);
    xfer(0, 0, 32'h0, 32'h0, 4'h0, 0, rd, er, cyc);
    chk("oor_noalias", rd, 32'd0);
    xfer(0, 0, 32'h8, 32'h0, 4'h0, 0, rd, er, cyc);
    chk("oor_unchanged", rd, 32'hDEAD3344);
    xfer(0, 0, 32'h2, 32'h0, 4'h0, 0, rd, er, cyc);
    chk("mis_cyc", 32'(cyc), 32'd2);
    chk("mis_err", 32'(er), 32'd1);
    chk("mis_data", rd, 32'd0);

    // Zero strobes
    xfer(0, 0, 32'h8, 32'h0, 4'h0, 0, rd, er, cyc);
    xfer(0, 1, 32'h8, 32'hFFFFFFFF, 4'h0, 0,
         rd, er, cyc);
    chk("strb0_err", 32'(er), 32'd0);
    chk("prdata_hold", prdata0, 32'hDEAD3344);
    xfer(0, 0, 32'h8, 32'h0, 4'h0, 0, rd, er, cyc);
    chk("strb0_data", rd, 32'hDEAD3344);

    // Back-to-back write then read
    xfer(0, 1, 32'hC, 32'hCAFEF00D, 4'hF, 1,
         rd, er, cyc);
    chk("b2b_wr_cyc", 32'(cyc), 32'd2);
    xfer(0, 0, 32'hC, 32'h0, 4'h0, 0, rd, er, cyc);
    chk("b2b_rd_cyc", 32'(cyc), 32'd2);
    chk("b2b_rd_data", rd, 32'hCAFEF00D);

    // Abort in WAIT
    psel0 = 1'b1; pen = 1'b0; pwrite = 1'b1;
    paddr = 32'h10; pwdata = 32'h12345678;
    pstrb = 4'hF;
    @(negedge pclk);
    psel0 = 1'b0;
    @(negedge pclk);
    chk("abort_pready", 32'(pready0), 32'd0);
    @(negedge pclk);
    xfer(0, 0, 32'h10, 32'h0, 4'h0, 0, rd, er, cyc);
    chk("abort_data", rd, 32'd0);

    // Three wait states
    xfer(1, 1, 32'h4, 32'hA5A5A5A5, 4'hF, 0,
         rd, er, cyc);
    chk("ws3_wr_cyc", 32'(cyc), 32'd5);
    xfer(1, 0, 32'h4, 32'h0, 4'h0, 0, rd, er, cyc);
    chk("ws3_rd_cyc", 32'(cyc), 32'd5);
    chk("ws3_rd_data", rd, 32'hA5A5A5A5);

    // Reset during WAIT of a write
    xfer(0, 0, 32'hC, 32'h0, 4'h0, 0, rd, er, cyc);
    chk("pre_rst_data", rd, 32'hCAFEF00D);
    psel0 = 1'b1; pen = 1'b0; pwrite = 1'b1;
    paddr = 32'h4; pwdata = 32'h00000055;
    pstrb = 4'hF;
    @(negedge pclk);
    pen = 1'b1;
    #2 prst = 1'b0;
    #1;
    chk("mid_rst_prdata", prdata0, 32'd0);
    chk("mid_rst_pready", 32'(pready0), 32'd0);
    @(negedge pclk);
    psel0 = 1'b0; pen = 1'b0;
    @(negedge pclk);
    prst = 1'b1;
    xfer(0, 0, 32'h4, 32'h0, 4'h0, 0, rd, er, cyc);
    chk("post_rst_cyc", 32'(cyc), 32'd2);
    chk("post_rst_4", rd, 32'd0);
    xfer(0, 0, 32'hC, 32'h0, 4'h0, 0, rd, er, cyc);
    chk("post_rst_C", rd, 32'd0);
    xfer(1, 0, 32'h4, 32'h0, 4'h0, 0, rd, er, cyc);
    chk("post_rst_ws3", rd, 32'd0);

    $display("%0d/%0d checks passed",
             total - fails, total);
    $finish;
  end

endmodule
